// File: rtl/count_capture_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_capture_fifo_if : producer/consumer handshake bundle  (rev 1.0)
// ---------------------------------------------------------------------------
interface count_capture_fifo_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface
`default_nettype wire

// File: rtl/count_capture_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// count_capture_fifo : captures counter values into a FIFO with redundant
// occupancy/free-slot counters and sticky consistency checks  (rev 1.0)
// ---------------------------------------------------------------------------
module count_capture_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  wire logic          clk,
   input  wire logic          rst,
   count_capture_fifo_if.slave fifo,
   output logic [PW:0]        occupancy,
   output logic [PW:0]        free_slots,
   output logic               inv_err,
   output logic               seq_err,
   output logic [PW-1:0]      wr_ptr_o,
   output logic [PW-1:0]      rd_ptr_o
);
   localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(DEPTH);
   localparam logic [PW+1:0] DEPTH_SUM = (PW+2)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] last_data;
   logic             have_last;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] next_seq;
   logic [PW+1:0]    count_sum;

   assign fifo.in_ready  = (occupancy != DEPTH_CNT);
   assign fifo.out_valid = (occupancy != '0);
   assign fifo.out_data  = mem[rd_ptr];

   assign push      = fifo.in_valid & fifo.in_ready;
   assign pop       = fifo.out_valid & fifo.out_ready;
   assign next_seq  = last_data + 1'b1;
   // Widened by one bit so a corrupted pair cannot wrap back to DEPTH.
   assign count_sum = {1'b0, occupancy} + {1'b0, free_slots};

   assign wr_ptr_o = wr_ptr;
   assign rd_ptr_o = rd_ptr;

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= fifo.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         free_slots <= DEPTH_CNT;
         inv_err    <= 1'b0;
         seq_err    <= 1'b0;
         have_last  <= 1'b0;
         last_data  <= '0;
      end else begin
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            last_data <= fifo.in_data;
            have_last <= 1'b1;
            if (have_last && (fifo.in_data != next_seq)) begin
               seq_err <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10: begin
               occupancy  <= occupancy + 1'b1;
               free_slots <= free_slots - 1'b1;
            end
            2'b01: begin
               occupancy  <= occupancy - 1'b1;
               free_slots <= free_slots + 1'b1;
            end
            default: ;
         endcase
         if (count_sum != DEPTH_SUM) begin
            inv_err <= 1'b1;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_count_capture_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_count_capture_fifo : directed and randomised checks of count_capture_fifo
// ---------------------------------------------------------------------------
module tb_count_capture_fifo;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int PW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [PW:0]   occupancy;
   logic [PW:0]   free_slots;
   logic          inv_err;
   logic          seq_err;
   logic [PW-1:0] wr_ptr_o;
   logic [PW-1:0] rd_ptr_o;

   int checks = 0;
   int passes = 0;

   count_capture_fifo_if #(.WIDTH(WIDTH)) bus ();

   count_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo       (bus),
      .occupancy  (occupancy),
      .free_slots (free_slots),
      .inv_err    (inv_err),
      .seq_err    (seq_err),
      .wr_ptr_o   (wr_ptr_o),
      .rd_ptr_o   (rd_ptr_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Apply inputs for one clock, then settle 1 time unit past the edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 4'd0, 1'b0);
      rst = 1'b0;
   endtask

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] cnt;
   logic             v, r, exp_push, exp_pop;

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

      // Reset state
      do_reset();
      check("rst_occ", occupancy, 0);
      check("rst_free", free_slots, 4);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_errs", {inv_err, seq_err}, 0);
      check("rst_ptrs", {wr_ptr_o, rd_ptr_o}, 0);

      // Three pushes, no consumer
      for (int i = 0; i < 3; i++) step(1'b1, 4'(i), 1'b0);
      check("t1_occ", occupancy, 3);
      check("t1_free", free_slots, 1);
      check("t1_out_data", bus.out_data, 0);
      check("t1_in_ready", bus.in_ready, 1);
      check("t1_errs", {inv_err, seq_err}, 0);

      // Fill, drop on full, drain
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 1'b0);
      check("t2_full_occ", occupancy, 4);
      check("t2_full_in_ready", bus.in_ready, 0);
      step(1'b1, 4'd4, 1'b0);
      check("t2_drop_occ", occupancy, 4);
      check("t2_drop_wr_ptr", wr_ptr_o, 0);
      for (int i = 0; i < 4; i++) begin
         check("t2_drain_valid", bus.out_valid, 1);
         check("t2_drain_data", bus.out_data, 32'(i));
         step(1'b0, 4'd0, 1'b1);
      end
      check("t2_empty_valid", bus.out_valid, 0);
      check("t2_seq_err", seq_err, 0);

      // Streaming with a legal 15 -> 0 wrap
      do_reset();
      begin
         logic [WIDTH-1:0] vals [4];
         vals = '{4'd14, 4'd15, 4'd0, 4'd1};
         for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b1);
            check("t3_occ", occupancy, 1);
            check("t3_head", bus.out_data, 32'(vals[i]));
         end
      end
      step(1'b0, 4'd0, 1'b1);
      check("t3_final_occ", occupancy, 0);
      check("t3_seq_err", seq_err, 0);

      // Sequence break 3 -> 5
      do_reset();
      step(1'b1, 4'd3, 1'b0);
      check("t4_seq_first", seq_err, 0);
      step(1'b1, 4'd5, 1'b0);
      check("t4_seq_set", seq_err, 1);
      step(1'b0, 4'd0, 1'b0);
      check("t4_seq_sticky", seq_err, 1);
      check("t4_head0", bus.out_data, 3);
      step(1'b0, 4'd0, 1'b1);
      check("t4_head1", bus.out_data, 5);
      step(1'b0, 4'd0, 1'b1);
      check("t4_drained", occupancy, 0);
      check("t4_seq_still", seq_err, 1);
      check("t4_inv_err", inv_err, 0);

      // Reset mid-operation with push and pop requested
      do_reset();
      step(1'b1, 4'd7, 1'b0);
      step(1'b1, 4'd9, 1'b0);
      check("t5_pre_occ", occupancy, 2);
      check("t5_pre_seq", seq_err, 1);
      rst = 1'b1;
      step(1'b1, 4'd10, 1'b1);
      rst = 1'b0;
      check("t5_occ", occupancy, 0);
      check("t5_free", free_slots, 4);
      check("t5_ptrs", {wr_ptr_o, rd_ptr_o}, 0);
      check("t5_out_valid", bus.out_valid, 0);
      check("t5_errs", {inv_err, seq_err}, 0);
      step(1'b1, 4'd9, 1'b0);
      check("t5_first_unchecked", seq_err, 0);
      check("t5_head", bus.out_data, 9);

      // Random push/pop against a queue model
      do_reset();
      q.delete();
      cnt = 4'd0;
      for (int c = 0; c < 1000; c++) begin
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         exp_push = v && (q.size() != DEPTH);
         exp_pop  = r && (q.size() != 0);
         check("t6_in_ready", bus.in_ready, (q.size() != DEPTH) ? 1 : 0);
         if (exp_pop) check("t6_order", bus.out_data, 32'(q[0]));
         step(v, cnt, r);
         if (exp_pop) void'(q.pop_front());
         if (exp_push) begin
            q.push_back(cnt);
            cnt = cnt + 1'b1;
         end
         check("t6_occ", occupancy, 32'(q.size()));
         check("t6_sum", 32'(occupancy) + 32'(free_slots), DEPTH);
      end
      check("t6_inv_err", inv_err, 0);
      check("t6_seq_err", seq_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
- Downstream stage of the enable-driven 4-bit counter; captures each counter output value on an enable pulse into a small FIFO for a consumer.
- Keeps an explicit occupancy count plus a redundant implicit free-slot count, so invariant synthesis has a relational constraint to discover: occupancy + free_slots == DEPTH.
- Flags sticky errors when that relation breaks or captured values are not consecutive.

Parameters:
- WIDTH, 4, data width; matches the counter output.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  capture request; tied to the counter enable.
- in_data  input  WIDTH  counter output value to capture.
- in_ready  output  1  FIFO can accept; equals (occupancy != DEPTH).
- out_valid  output  1  head entry available; equals (occupancy != 0).
- out_data  output  WIDTH  head entry, combinational read of mem[rd_ptr].
- out_ready  input  1  consumer accepts head.
- occupancy  output  PW+1  explicit entry count (modelled state).
- free_slots  output  PW+1  implicit free-entry count (micro-arch state).
- inv_err  output  1  sticky; the occupancy/free_slots relation has been violated.
- seq_err  output  1  sticky; a captured value was not the previous capture + 1 mod 2^WIDTH.
- wr_ptr_o  output  PW  write pointer, exported for property checking.
- rd_ptr_o  output  PW  read pointer, exported for property checking.

Behaviour:
Reset (rst = 1 at posedge):
- wr_ptr = rd_ptr = 0; occupancy = 0; free_slots = DEPTH.
- inv_err = 0; seq_err = 0; have_last = 0; last_data = 0.
- Memory contents are not reset.
- Immediately after reset: out_valid = 0, in_ready = 1.
- Reset has priority over push/pop in the same cycle. Reset mid-operation discards all entries; no partial updates.

Transfer conditions:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.

Push:
- mem[wr_ptr] <= in_data; wr_ptr <= wr_ptr + 1, wrapping mod DEPTH.

Pop:
- rd_ptr <= rd_ptr + 1, wrapping mod DEPTH.

Counters (all cases below):
- push only: occupancy +1, free_slots -1.
- pop only: occupancy -1, free_slots +1.
- push and pop together: both counters unchanged, both pointers advance.
- neither: no change.

Boundary conditions:
- Full (occupancy == DEPTH): in_ready = 0, so in_valid is ignored and the value is dropped; pop is still allowed.
- Empty: out_valid = 0, so out_ready is ignored; a push in the same cycle becomes visible on out_data the next cycle. No bypass; minimum latency is 1 cycle.
- Simultaneous push and pop at occupancy 1: the head pops and the new entry becomes head; occupancy stays 1.

Latency:
- Captured value appears at the head 1 cycle after push when the FIFO was empty.

Sequence check:
- On push with have_last = 1: if in_data != last_data + 1 (WIDTH-bit wrap, so 4'hf -> 4'h0 is legal), set seq_err.
- On every push: last_data <= in_data; have_last <= 1.
- The first push after reset is never checked.

Invariant check:
- Each cycle not in reset: if (occupancy + free_slots) != DEPTH, compared on registered values in PW+2 bits to avoid overflow, set inv_err.
- Both error flags stay set until rst; they do not affect datapath behaviour.

Arithmetic:
- All counter updates are modulo their register width.
- The design guarantees occupancy <= DEPTH and free_slots <= DEPTH in every reachable state.

Test Plan:
1. Reset, then push 0,1,2 on consecutive cycles with out_ready = 0 -> occupancy = 3, free_slots = 1, out_data = 0, in_ready = 1, no errors.
2. Push 0,1,2,3,4 with out_ready = 0 -> after 4 pushes occupancy = 4, in_ready = 0; value 4 dropped; pop 4 times with out_ready = 1 -> out_data sequence 0,1,2,3, then out_valid = 0.
3. Steady stream of values 14,15,0,1 with out_ready = 1 every cycle -> occupancy holds at 1 after the first push; outputs 14,15,0,1 each 1 cycle late; seq_err = 0, because 15 -> 0 wraps legally.
4. Push 3 then 5 -> seq_err = 1 the cycle after the second push and stays 1; data 3 and 5 are still delivered in order.
5. Fill to occupancy 2, assert rst for 1 cycle together with in_valid = 1 and out_ready = 1 -> occupancy = 0, free_slots = 4, pointers = 0, out_valid = 0, errors cleared; next push of 9 is not sequence-checked.
6. Random push/pop over 1000 cycles -> occupancy + free_slots == 4 every cycle, inv_err never set, output order equals input order.
